// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
// Holds the arbitration FSM encoding and the DW/AW default widths.
package sram_arb_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester bus of the SRAM arbiter: req/we/addr/data/lock per requester,
// gnt/rvalid per requester, shared q. master = requesters, slave = arbiter.
interface sram_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 6
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          lock0;
  logic          lock1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] q;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, data0, data1,
    output lock0, lock1,
    input  gnt0, gnt1, rvalid0, rvalid1, q
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, data0, data1,
    input  lock0, lock1,
    output gnt0, gnt1, rvalid0, rvalid1, q
  );

endinterface

// File: rtl/sram_core.sv
// Single-port DW x 2**AW RAM with registered read address; no reset.
// Ports: clk, wr (write strobe), rd (read strobe), addr, wdata, q.
module sram_core
  import sram_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          wr,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] addr_q;

  // Only reads move the address register, so q keeps
  // showing the last read location across writes and idles.
  always_ff @(posedge clk) begin
    if (wr) mem[addr] <= wdata;
    if (rd) addr_q <= addr;
  end

  assign q = mem[addr_q];

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter with lock in front of a single-port SRAM.
// Ports: clk, rst (sync, active-high), bus (slave modport of
// sram_arbiter_if). Define SRAM_ARB_RR_EN for round-robin, else fixed prio.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  arb_state_t    state;
  arb_state_t    nxt;
  logic          g0;
  logic          g1;
  logic          hold0;
  logic          hold1;
  logic          pref;
  logic          rv0;
  logic          rv1;
  logic          ram_wr;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;

  // A lock state whose lock bit has dropped arbitrates as IDLE.
  assign hold0 = (state == LOCK0) && bus.lock0;
  assign hold1 = (state == LOCK1) && bus.lock1;

`ifdef SRAM_ARB_RR_EN
  logic ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (!hold0 && !hold1 && (g0 || g1)) begin
      ptr <= g0;
    end
  end

  assign pref = ptr;
`else
  assign pref = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = IDLE;
    g0  = 1'b0;
    g1  = 1'b0;
    unique case (1'b1)
      hold0: begin
        g0  = bus.req0;
        nxt = LOCK0;
      end
      hold1: begin
        g1  = bus.req1;
        nxt = LOCK1;
      end
      default: begin
        if (bus.req0 && bus.req1) begin
          g0 = ~pref;
          g1 = pref;
        end else begin
          g0 = bus.req0;
          g1 = bus.req1;
        end
        if (g0 && bus.lock0) nxt = LOCK0;
        else if (g1 && bus.lock1) nxt = LOCK1;
      end
    endcase
    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  // Cleared on the reset edge; also masked during reset so a read
  // granted just before reset never shows its rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      rv0 <= g0 && !bus.we0;
      rv1 <= g1 && !bus.we1;
    end
  end

  assign bus.gnt0    = g0;
  assign bus.gnt1    = g1;
  assign bus.rvalid0 = rv0 && !rst;
  assign bus.rvalid1 = rv1 && !rst;

  assign ram_wr    = (g0 && bus.we0) || (g1 && bus.we1);
  assign ram_rd    = (g0 && !bus.we0) || (g1 && !bus.we1);
  assign ram_addr  = g1 ? bus.addr1 : bus.addr0;
  assign ram_wdata = g1 ? bus.data1 : bus.data0;

  sram_core #(
    .DW (DW),
    .AW (AW)
  ) u_core (
    .clk   (clk),
    .wr    (ram_wr),
    .rd    (ram_rd),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (bus.q)
  );

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DW, default 8, RAM data width in bits.
REQ-002 Parameter AW, default 6, RAM address width in bits (depth 2**AW = 64 words).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0, req1  input  1 each  access request from requester 0 and requester 1; held high until granted.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; qualified by the matching req.
REQ-007 addr0, addr1  input  AW each  access address for each requester.
REQ-008 data0, data1  input  DW each  write data for each requester.
REQ-009 lock0, lock1  input  1 each  while high, the current owner keeps the RAM on later cycles.
REQ-010 gnt0, gnt1  output  1 each  access accepted this cycle; combinational and one-hot-or-zero.
REQ-011 rvalid0, rvalid1  output  1 each  read data valid for that requester, one cycle after a granted read.
REQ-012 q  output  DW  RAM read data, shared by both requesters.

Function
REQ-013 The block SHALL grant at most one requester per cycle and SHALL drive the RAM with the granted requester's we/addr/data in that same cycle.
REQ-014 The RAM SHALL be single-port with a registered address: a write commits at the grant edge, and a read returns mem[addr] on q in the following cycle.
REQ-015 Read latency SHALL be exactly 1 cycle from grant to rvalid; rvalidN SHALL be high for exactly one cycle per granted read.
REQ-016 A granted write SHALL NOT assert rvalid.
REQ-017 With no grant in a cycle, RAM we SHALL be 0 and q SHALL hold the last read address's contents.
REQ-018 The arbitration FSM SHALL have states IDLE, LOCK0 and LOCK1.
REQ-019 In IDLE, a single requester SHALL be granted immediately; when both request, priority follows REQ-031/032.
REQ-020 A grant with the matching lockN high SHALL move the FSM to LOCKN.
REQ-021 In LOCKN, only requester N SHALL be granted; the other requester is stalled even if N is idle.
REQ-022 The FSM SHALL leave LOCKN for IDLE on the first cycle in which lockN is low, and that cycle SHALL be arbitrated as IDLE.
REQ-023 A read and a write to the same address in consecutive grants SHALL read the new data, since the write commits before the registered read address is used.
REQ-024 Requests for an out-of-range address cannot occur; the address wraps modulo 2**AW.

Reset
REQ-025 While rst is high: FSM = IDLE, round-robin pointer = 0, rvalid0 = rvalid1 = 0, RAM we forced 0.
REQ-026 During reset, gnt0 and gnt1 SHALL be 0.
REQ-027 RAM contents SHALL NOT be cleared by reset, and q SHALL be undefined until the first read.
REQ-028 A reset asserted mid-lock SHALL abort the lock, and a read granted in the cycle before reset SHALL NOT produce rvalid after reset.

Configuration
REQ-029 Macro SRAM_ARB_RR_EN selects the arbitration policy.
REQ-030 With SRAM_ARB_RR_EN defined, the policy SHALL be round-robin.
REQ-031 Under round-robin, a 1-bit pointer names the preferred requester; on each granted cycle in IDLE it moves to the non-granted requester.
REQ-032 With SRAM_ARB_RR_EN undefined, the policy SHALL be fixed priority: requester 0 always wins in IDLE, and no pointer register exists.

Structure
REQ-033 A shared package sram_arb_pkg SHALL hold the FSM state encoding (IDLE, LOCK0, LOCK1) and the DW/AW default constants.
REQ-034 The RAM storage (registered-address single-port array, DW x 2**AW) SHALL be one sub-module, sram_core, instanced once.
REQ-035 The arbitration FSM and the rvalid pipeline SHALL remain in sram_arbiter.

Verification
REQ-036 Test 1: req0 write addr 5 data 0xA5, then req1 read addr 5 -> gnt0 in cycle 0, gnt1 in cycle 1, rvalid1 = 1 with q = 0xA5 in cycle 2.
REQ-037 Test 2: req0 and req1 both held high, reads of addr 1 and 2, RR_EN defined -> grants alternate 0,1,0,1, and each rvalid matches its requester one cycle later.
REQ-038 Test 3: same stimulus as Test 2 with RR_EN undefined -> gnt0 every cycle and gnt1 never.
REQ-039 Test 4: lock0 high for 3 grants while req1 is held high -> gnt1 stays 0 for those 3 cycles, then is granted on the cycle after lock0 falls.
REQ-040 Test 5: rst pulsed in LOCK1 right after a granted read -> no rvalid1 after reset, and the first post-reset contention follows the reset pointer (requester 0 wins).
REQ-041 Test 6: write addr 63 data 0x3C, then read addr 63 and addr 0 back-to-back -> q = 0x3C then the addr-0 contents, each with one rvalid pulse.
